// File: rtl/fpga_link_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fpga_link_rx_buffer
// Purpose  : Acknowledging receive FIFO behind fpga_protocol; back-pressures when full.
// Revision : 1.0
// ============================================================================
module fpga_link_rx_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        link_data,
    input  logic              link_received,
    output logic              link_processed,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       total_bytes
);

    localparam logic [1:0]      c_st_idle      = 2'd0;
    localparam logic [1:0]      c_st_ack       = 2'd1;
    localparam logic [1:0]      c_st_wait_drop = 2'd2;
    localparam logic [ADDR_W:0] c_full_level   = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [15:0]       r_total;
    logic [7:0]        r_rd_data;
    logic              r_rd_valid;
    logic              w_empty;
    logic              w_full;
    logic              w_wr_en;
    logic              w_rd_en;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_full_level);

    // Eligibility uses the registered full flag, so a same-cycle read never frees a slot early
    assign w_wr_en = (r_state == c_st_idle) && link_received && !w_full;
    assign w_rd_en = rd_en && !w_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:      if (w_wr_en)        w_next_state = c_st_ack;
            c_st_ack:                           w_next_state = c_st_wait_drop;
            c_st_wait_drop: if (!link_received) w_next_state = c_st_idle;
            default:                            w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= link_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_total    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                r_total  <= r_total + 16'd1;
            end
            if (w_rd_en) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign link_processed = (r_state == c_st_ack);
    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign empty          = w_empty;
    assign full           = w_full;
    assign level          = r_level;
    assign total_bytes    = r_total;

endmodule
`default_nettype wire

// File: tb/tb_fpga_link_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_link_rx_buffer
// Purpose  : Vector table, directed corner sequences and random scoreboard run.
// Revision : 1.0
// ============================================================================
module tb_fpga_link_rx_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  link_data = 8'h00;
    logic        link_received = 1'b0;
    logic        link_processed;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic [15:0] total_bytes;

    int checks = 0;
    int errors = 0;

    fpga_link_rx_buffer #(.DEPTH(16), .ADDR_W(4)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .link_data      (link_data),
        .link_received  (link_received),
        .link_processed (link_processed),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .empty          (empty),
        .full           (full),
        .level          (level),
        .total_bytes    (total_bytes)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        recv;
        logic [7:0]  data;
        logic        rd;
        logic        exp_proc;
        logic        exp_valid;
        logic [7:0]  exp_rdata;
        logic [4:0]  exp_level;
        logic [15:0] exp_total;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_processed"}, link_processed, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_total"}, total_bytes, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; link_received = 1'b0; rd_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Acts as the protocol side: offer a byte, wait for the acknowledge, drop and stay low.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        link_data = b;
        link_received = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (link_processed) got = 1'b1;
        end
        if (!got) chk("send_timeout", 0, 1);
        link_received = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic read_expect(input string name, input logic [7:0] exp);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        chk({name, "_valid"}, rd_valid, 1);
        chk({name, "_data"}, rd_data, exp);
    endtask

    logic [7:0] burst[11] = '{8'd45, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128, 8'd255, 8'd99, 8'd3};

    initial begin
        int procs;
        bit pending;
        int hold_left, gap, prev_size, acc;
        logic prev_recv, prev_rd, exp_v, exp_p;
        logic [7:0] prev_data, last_rd;
        logic [7:0] q[$];

        vecs[0] = '{1'b1, 8'd45, 1'b0, 1'b1, 1'b0, 8'd0,  5'd1, 16'd1};
        vecs[1] = '{1'b1, 8'd45, 1'b0, 1'b0, 1'b0, 8'd0,  5'd1, 16'd1};
        vecs[2] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  5'd1, 16'd1};
        vecs[3] = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 8'd45, 5'd0, 16'd1};
        vecs[4] = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd45, 5'd0, 16'd1};
        vecs[5] = '{1'b1, 8'd7,  1'b0, 1'b1, 1'b0, 8'd45, 5'd1, 16'd2};
        vecs[6] = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 8'd7,  5'd0, 16'd2};
        vecs[7] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd7,  5'd0, 16'd2};
        vecs[8] = '{1'b1, 8'd9,  1'b0, 1'b1, 1'b0, 8'd7,  5'd1, 16'd3};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_reset_vals("reset");

        // Table: single byte, read, read-on-empty, back-to-back transfers
        foreach (vecs[i]) begin
            link_received = vecs[i].recv;
            link_data     = vecs[i].data;
            rd_en         = vecs[i].rd;
            @(negedge clock);
            chk($sformatf("vec%0d_processed", i), link_processed, vecs[i].exp_proc);
            chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
            chk($sformatf("vec%0d_empty", i), empty, vecs[i].exp_level == 0);
            chk($sformatf("vec%0d_total", i), total_bytes, vecs[i].exp_total);
        end

        // Long received: one write, one pulse
        do_reset();
        link_received = 1'b1; link_data = 8'h5A;
        procs = 0;
        repeat (22) begin
            @(negedge clock);
            if (link_processed) procs++;
        end
        chk("long_recv_pulses", procs, 1);
        chk("long_recv_level", level, 1);
        chk("long_recv_total", total_bytes, 1);
        link_received = 1'b0;
        repeat (2) @(negedge clock);
        read_expect("long_recv_rd", 8'h5A);

        // Burst in order
        do_reset();
        foreach (burst[i]) send_byte(burst[i]);
        chk("burst_level", level, 11);
        chk("burst_total", total_bytes, 11);
        foreach (burst[i]) read_expect($sformatf("burst_rd%0d", i), burst[i]);
        chk("burst_empty", empty, 1);

        // Full and back-pressure, then pointer wrap on drain
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("full_flag", full, 1);
        chk("full_level", level, 16);
        link_received = 1'b1; link_data = 8'hAA;
        procs = 0;
        repeat (50) begin
            @(negedge clock);
            if (link_processed) procs++;
        end
        chk("bp_no_ack", procs, 0);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        chk("bp_read_valid", rd_valid, 1);
        chk("bp_read_data", rd_data, 8'h00);
        chk("bp_no_ack_on_read", link_processed, 0);
        chk("bp_level_after_read", level, 15);
        @(negedge clock);
        chk("bp_ack_after_read", link_processed, 1);
        chk("bp_level_refill", level, 16);
        chk("bp_total", total_bytes, 17);
        link_received = 1'b0;
        repeat (2) @(negedge clock);
        for (int i = 1; i < 16; i++) read_expect($sformatf("wrap_rd%0d", i), 8'(i));
        read_expect("wrap_rd_aa", 8'hAA);
        chk("wrap_empty", empty, 1);

        // Simultaneous read and write at level 5
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'(10 + i));
        link_received = 1'b1; link_data = 8'h77; rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        chk("simul_processed", link_processed, 1);
        chk("simul_rd_valid", rd_valid, 1);
        chk("simul_rd_data", rd_data, 8'd10);
        chk("simul_level", level, 5);
        link_received = 1'b0;
        repeat (2) @(negedge clock);

        // Reset during the acknowledge cycle, then recapture of the still-held byte
        do_reset();
        send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
        read_expect("mid_pre_rd", 8'h21);
        link_received = 1'b1; link_data = 8'h33;
        procs = 0;
        for (int i = 0; i < 50 && procs == 0; i++) begin
            @(negedge clock);
            if (link_processed) procs = 1;
        end
        chk("mid_ack_seen", procs, 1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("mid_ack_reset");
        reset = 1'b0;
        @(negedge clock);
        chk("recapture_processed", link_processed, 1);
        chk("recapture_level", level, 1);
        chk("recapture_total", total_bytes, 1);
        link_received = 1'b0;
        repeat (2) @(negedge clock);

        // Random traffic against a queue model of the FIFO and handshake
        do_reset();
        pending = 1'b0; hold_left = 0; gap = 0; prev_size = 0; acc = 0;
        prev_recv = 1'b0; prev_rd = 1'b0; prev_data = 8'h00; last_rd = 8'h00;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            exp_v = prev_rd && (prev_size > 0);
            chk("rand_rd_valid", rd_valid, exp_v);
            if (exp_v) last_rd = q.pop_front();
            chk("rand_rd_data", rd_data, last_rd);
            exp_p = prev_recv && pending && (prev_size < 16);
            chk("rand_processed", link_processed, exp_p);
            if (exp_p) begin
                q.push_back(prev_data);
                acc++;
                pending = 1'b0;
                hold_left = $urandom_range(0, 4);
            end
            chk("rand_level", level, q.size());
            chk("rand_empty", empty, q.size() == 0);
            chk("rand_full", full, q.size() == 16);
            chk("rand_total", total_bytes, acc & 16'hFFFF);

            if (link_received && !pending) begin
                if (hold_left > 0) hold_left--;
                else begin
                    link_received = 1'b0;
                    gap = 2;
                end
            end else if (!link_received) begin
                if (gap > 0) gap--;
                if (gap == 0 && $urandom_range(0, 2) == 0) begin
                    link_received = 1'b1;
                    link_data = 8'($urandom);
                    pending = 1'b1;
                end
            end
            if (cyc < 2000) rd_en = ($urandom_range(0, 15) == 0);
            else            rd_en = ($urandom_range(0, 3) != 0);
            prev_recv = link_received;
            prev_data = link_data;
            prev_rd   = rd_en;
            prev_size = q.size();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpga_link_rx_buffer.md
# fpga_link_rx_buffer

Receive-side buffer that sits directly downstream of `fpga_protocol`. It consumes each byte presented on the protocol's `data_out`/`received` outputs and acknowledges it with a one-cycle `processed` pulse. Accepted bytes are stored in an internal FIFO that local logic drains at its own pace. When the FIFO is full, the block withholds the acknowledge, which back-pressures the FPGA-to-FPGA link instead of dropping data.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `ADDR_W`, 4, log2(`DEPTH`)

- `clock`  in  1  single system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `link_data`  in  8  byte from `fpga_protocol.data_out`; valid while `link_received`=1
- `link_received`  in  1  from `fpga_protocol.received`; level, held until acknowledged
- `link_processed`  out  1  to `fpga_protocol.processed`; one-cycle acknowledge pulse
- `rd_en`  in  1  local read request
- `rd_data`  out  8  read byte, registered
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid this cycle
- `empty`  out  1  FIFO holds 0 bytes
- `full`  out  1  FIFO holds `DEPTH` bytes
- `level`  out  `ADDR_W`+1  current FIFO occupancy, 0..`DEPTH`
- `total_bytes`  out  16  count of bytes accepted since reset; wraps 0xFFFF→0x0000

## Operation
- Link FSM states:
  - IDLE: if `link_received`=1 and `full`=0, write `link_data` into FIFO at `wr_ptr`, increment `total_bytes`, go to ACK. If `full`=1, stay in IDLE; no write, no acknowledge.
  - ACK: `link_processed`=1 for exactly this state; go to WAIT_DROP unconditionally.
  - WAIT_DROP: `link_processed`=0; stay until `link_received`=0, then go to IDLE.
- WAIT_DROP guarantees one write per protocol transfer, even when `received` stays high for many cycles after the acknowledge.
- FIFO: `DEPTH`×8 storage. `wr_ptr` and `rd_ptr` are `ADDR_W` bits and wrap naturally at `DEPTH`. `level` is tracked explicitly.
- Read: `rd_en`=1 and `empty`=0 → `rd_data` ← mem[`rd_ptr`], `rd_ptr`++, `rd_valid`=1 next cycle.
- Read while `empty`=1 is ignored: `rd_valid` stays 0, `rd_data` holds its value, no pointer change.
- Simultaneous write and read in one cycle: both happen and `level` is unchanged.
- Write eligibility uses the registered `full` of the current cycle. A read in the same cycle as `full`=1 does not enable a write in that cycle; the write happens on the next IDLE evaluation.
- `empty` = (`level`==0), `full` = (`level`==`DEPTH`), both derived from registered `level`.
- `level` never exceeds `DEPTH` and never underflows.

## Timing
- Reset values: `link_processed`=0, `rd_data`=0x00, `rd_valid`=0, `empty`=1, `full`=0, `level`=0, `total_bytes`=0. FSM=IDLE, pointers=0.
- Capture: `link_received` sampled high in IDLE at cycle N → byte written at edge ending N. `level`/`total_bytes` update visible at N+1. `link_processed`=1 during N+1 only.
- Minimum 3 cycles per byte (IDLE, ACK, WAIT_DROP with `received` already low).
- Read latency: `rd_en` at cycle N → `rd_data`/`rd_valid` at N+1. A byte written at N is readable by `rd_en` at N+1.
- Back-pressure: while `full`=1, `link_processed` stays 0 indefinitely. After the first read lowers `level`, capture occurs at the next IDLE cycle with `full`=0.
- Reset mid-operation (any state): all outputs return to reset values at the next edge and stored bytes are discarded. If `link_received` is still 1 after reset, the byte is captured again from IDLE.

## Test plan
- Single byte: `link_data`=45, `link_received` held high → one write, `link_processed` high exactly 1 cycle, `level`=1, `total_bytes`=1. After `received` drops, `rd_en` → `rd_data`=45, `rd_valid`=1, `empty`=1.
- Burst: transfer 45, 2, 4, 8, 16, 32, 64, 128, 255, 99, 3 with no reads → `level`=11, `total_bytes`=11. Eleven reads return the same order, then `empty`=1.
- Long `received`: hold `link_received`=1 for 20 cycles after the acknowledge → exactly one write, exactly one `link_processed` pulse.
- Full/back-pressure: fill 16 bytes, present 0xAA → `full`=1, `link_processed` stays 0 for 50 cycles. One `rd_en` → 0xAA accepted on the next IDLE cycle and `level` returns to 16.
- Simultaneous/empty edges: `rd_en` on empty → `rd_valid`=0. Read and write in the same cycle at `level`=5 → `level` stays 5. Sixteen-plus writes and reads wrap the pointers with no data corruption.
- Reset mid-ACK: assert `reset` during the cycle `link_processed`=1 → next cycle all outputs at reset values, `level`=0, `total_bytes`=0.
